// File: rtl/timer_pkg.sv
// timer_pkg: card-level delay constants for the on-delay timer.
// Both delays assume a 1.28 us system clock.
package timer_pkg;

  // 2 s qualification delay
  localparam int TM2S_WIDTH  = 21;
  localparam int TM2S_TARGET = 1562500;

  // 4 s qualification delay
  localparam int TM4S_WIDTH  = 22;
  localparam int TM4S_TARGET = 3125000;

  // Widths used by simulation builds
  localparam int TM_SIM_WIDTH = 4;

endpackage : timer_pkg

// File: rtl/timer_sat_up_counter.sv
// timer_sat_up_counter: up counter with enable and synchronous clear.
// The counter stops at `limit` and never wraps.
module timer_sat_up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  // Count register: reset/clear to zero, otherwise count up until limit.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count < limit)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : timer_sat_up_counter

// File: rtl/timer.sv
// timer: non-retentive on-delay (TON) timer.
// hit_target rises once `in` has been sampled high on `target` consecutive
// edges and falls combinationally with `in`.
// Optional build macro TIMER_ELAPSED_OUT_EN adds the `elapsed` and `running`
// observation ports; hit_target behaves identically either way.
module timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic             in,
`ifdef TIMER_ELAPSED_OUT_EN
  output logic [WIDTH-1:0] elapsed,
  output logic             running,
`endif
  output logic             hit_target
);

  logic [WIDTH-1:0] count;
  logic             reached;

  // A low sample clears the count; a high sample advances it up to target.
  // Lowering target below count simply freezes the count, and raising it
  // resumes counting from the current value.
  timer_sat_up_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (~in),
    .enable (in),
    .limit  (target),
    .count  (count)
  );

  // Unsigned WIDTH-bit compare; target=0 makes the output follow `in`.
  assign reached    = (count >= target);
  assign hit_target = in & reached;

`ifdef TIMER_ELAPSED_OUT_EN
  assign elapsed = count;
  assign running = in & ~reached;
`endif

endmodule : timer

// File: tb/tb_timer.sv
// tb_timer: directed self-checking bench for the on-delay timer (WIDTH=4).
module tb_timer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] target;
  logic         in;
  logic         hit_target;
`ifdef TIMER_ELAPSED_OUT_EN
  logic [W-1:0] elapsed;
  logic         running;
`endif

  int checks   = 0;
  int failures = 0;

  timer #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .target     (target),
    .in         (in),
`ifdef TIMER_ELAPSED_OUT_EN
    .elapsed    (elapsed),
    .running    (running),
`endif
    .hit_target (hit_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] toggle_pat;

  initial begin
    reset  = 1'b1;
    in     = 1'b0;
    target = 4'd8;
    tick();
    tick();

    // Reset state with in=0
    reset = 1'b0;
    #1;
    check("reset_hit", hit_target, 0);
`ifdef TIMER_ELAPSED_OUT_EN
    check("reset_elapsed", elapsed, 0);
    check("reset_running", running, 0);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_hit", hit_target, 0);
    end

    // Hold in high with target=8: assert after the 8th edge, no wrap
    in = 1'b1;
    #1;
    check("t8_start_hit", hit_target, 0);
    for (int i = 1; i <= 28; i++) begin
      tick();
      check($sformatf("t8_edge%0d_hit", i), hit_target, (i >= 8) ? 1 : 0);
`ifdef TIMER_ELAPSED_OUT_EN
      check($sformatf("t8_edge%0d_elapsed", i), elapsed, (i >= 8) ? 8 : i);
      check($sformatf("t8_edge%0d_running", i), running, (i >= 8) ? 0 : 1);
`endif
    end

    // Drop in while asserted: immediate release, count clears next edge
    in = 1'b0;
    #1;
    check("release_same_cycle", hit_target, 0);
    tick();
`ifdef TIMER_ELAPSED_OUT_EN
    check("release_elapsed", elapsed, 0);
`endif
    in = 1'b1;
    #1;
    check("rerun_start_hit", hit_target, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("rerun_edge%0d_hit", i), hit_target, (i == 8) ? 1 : 0);
    end
    in = 1'b0;
    tick();

    // target=15: 10 highs, 1 low, then restart needs the full 15 edges
    target = 4'd15;
    in     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t15_run1_edge%0d_hit", i), hit_target, 0);
    end
    in = 1'b0;
    #1;
    check("t15_gap_hit", hit_target, 0);
    tick();
    in = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("t15_run2_edge%0d_hit", i), hit_target, (i == 15) ? 1 : 0);
    end
    // All-ones target saturates without wrapping
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("t15_sat%0d_hit", i), hit_target, 1);
`ifdef TIMER_ELAPSED_OUT_EN
      check($sformatf("t15_sat%0d_elapsed", i), elapsed, 15);
`endif
    end

    // target=0: output follows in with zero latency
    target     = 4'd0;
    toggle_pat = 16'b1011_0010_1100_1101;
    for (int i = 0; i < 16; i++) begin
      in = toggle_pat[i];
      #1;
      check($sformatf("t0_cyc%0d_hit", i), hit_target, {31'd0, toggle_pat[i]});
      tick();
    end

    // target lowered/raised mid-count
    in     = 1'b0;
    target = 4'd15;
    tick();
    in = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    check("lower_pre_hit", hit_target, 0);
    target = 4'd5;
    #1;
    check("lower_immediate_hit", hit_target, 1);
    tick();
    check("lower_hold_hit", hit_target, 1);
`ifdef TIMER_ELAPSED_OUT_EN
    check("lower_hold_elapsed", elapsed, 10);
`endif
    target = 4'd15;
    #1;
    check("raise_immediate_hit", hit_target, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("raise_edge%0d_hit", i), hit_target, (i == 5) ? 1 : 0);
    end

    // Reset mid-count with in=1 restarts the full delay
    in     = 1'b0;
    target = 4'd8;
    tick();
    in = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midreset_hit", hit_target, 0);
`ifdef TIMER_ELAPSED_OUT_EN
    check("midreset_elapsed", elapsed, 0);
`endif
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("midreset_edge%0d_hit", i), hit_target, (i == 8) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_timer
